// File: rtl/sha_compress_if.sv
// rtl/sha_compress_if.sv - start/result bundle between the schedule expander and sha_compress
interface sha_compress_if #(
  parameter int WORD_S = 32
);
  logic                  en;
  logic [64*WORD_S-1:0]  W;
  logic [8*WORD_S-1:0]   H_in;
  logic [8*WORD_S-1:0]   H_out;
  logic                  en_next;
  logic                  busy;

  modport master (
    output en, W, H_in,
    input  H_out, en_next, busy
  );

  modport slave (
    input  en, W, H_in,
    output H_out, en_next, busy
  );
endinterface

// File: rtl/sha_compress.sv
// rtl/sha_compress.sv - iterative SHA-256 compression, one round per clock
// Optional macro SHA_COMPRESS_UNROLL2_EN: two chained rounds per clock (ROUNDS must be even).
module sha_compress #(
  parameter int ROUNDS = 64,
  parameter int WORD_S = 32
) (
  input  logic          clk,
  input  logic          reset,
  sha_compress_if.slave bus
);

  typedef logic [WORD_S-1:0]   word_t;
  typedef logic [8*WORD_S-1:0] state_vec_t;
  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

`ifdef SHA_COMPRESS_UNROLL2_EN
  localparam logic [6:0] STEP   = 7'd2;
  localparam logic [6:0] LAST_T = 7'(ROUNDS - 2);
`else
  localparam logic [6:0] STEP   = 7'd1;
  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);
`endif

  state_t     state;
  logic [6:0] t;
  state_vec_t v;
  state_vec_t v_next;
  state_vec_t h_reg;
  state_vec_t digest;
  word_t      w_mem [64];
  logic [5:0] t_idx;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (WORD_S - n));
  endfunction

  function automatic word_t k_const(input logic [5:0] idx);
    word_t k;
    case (idx)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
      default: k = '0;
    endcase
    return k;
  endfunction

  // Working vector packs a..h with a in the top word, same as H_in.
  function automatic state_vec_t round_fn(input state_vec_t s, input word_t k, input word_t w);
    word_t a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  assign t_idx = t[5:0];

`ifdef SHA_COMPRESS_UNROLL2_EN
  logic [5:0] t_idx1;
  assign t_idx1 = t_idx + 6'd1;
  assign v_next = round_fn(round_fn(v, k_const(t_idx), w_mem[t_idx]),
                           k_const(t_idx1), w_mem[t_idx1]);
`else
  assign v_next = round_fn(v, k_const(t_idx), w_mem[t_idx]);
`endif

  always_comb begin
    digest = '0;
    for (int i = 0; i < 8; i++) begin
      digest[i*WORD_S +: WORD_S] = h_reg[i*WORD_S +: WORD_S] + v[i*WORD_S +: WORD_S];
    end
  end

  // Block inputs are captured only on the accepting edge; upstream is free afterwards.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.en) begin
      h_reg <= bus.H_in;
      for (int i = 0; i < 64; i++) begin
        w_mem[i] <= bus.W[i*WORD_S +: WORD_S];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      t           <= '0;
      v           <= '0;
      bus.H_out   <= '0;
      bus.en_next <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.en_next <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en) begin
            v        <= bus.H_in;
            t        <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          v <= v_next;
          t <= t + STEP;
          if (t == LAST_T) begin
            state <= FINAL;
          end
        end
        FINAL: begin
          bus.H_out   <= digest;
          bus.en_next <= 1'b1;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_compress.sv
// tb/tb_sha_compress.sv - directed and random checks of sha_compress against a SHA-256 model
module tb_sha_compress;

`ifdef SHA_COMPRESS_UNROLL2_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 65;
`endif
  localparam int LIMIT = 200;

  localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sha_compress_if #(.WORD_S(32)) bus ();

  sha_compress #(.ROUNDS(64), .WORD_S(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] expand(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] s0, s1;
    logic [2047:0] p;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int t = 0; t < 64; t++) p[t*32 +: 32] = w[t];
    return p;
  endfunction

  function automatic logic [255:0] ref_compress(input logic [2047:0] wp, input logic [255:0] hin);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] out;
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wp[t*32 +: 32];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) out[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return out;
  endfunction

  function automatic logic [2047:0] rand_w();
    logic [2047:0] p;
    for (int i = 0; i < 64; i++) p[i*32 +: 32] = $urandom();
    return p;
  endfunction

  function automatic logic [255:0] rand_h();
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = $urandom();
    return p;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input bit immediate, input logic [2047:0] w, input logic [255:0] h);
    if (!immediate) @(negedge clk);
    bus.W = w;
    bus.H_in = h;
    bus.en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    bus.W = rand_w();
    bus.H_in = rand_h();
  endtask

  task automatic wait_done(input int inject_at, output int lat, output int bcnt, output int done_cyc);
    int n;
    n = 0;
    lat = -1;
    done_cyc = 0;
    bcnt = bus.busy ? 1 : 0;
    while (lat < 0 && n < LIMIT) begin
      if (n == inject_at) begin
        bus.en = 1'b1;
        bus.W = rand_w();
      end else begin
        bus.en = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.en_next) begin
        lat = n;
        done_cyc = cyc;
      end else if (bus.busy) begin
        bcnt++;
      end
    end
    bus.en = 1'b0;
  endtask

  logic [2047:0] w_abc, w_b1, w_b2, w_r;
  logic [255:0]  h_r, dig1;
  int lat, bcnt, dc1, dc2, pulses;

  initial begin
    bus.en = 1'b0;
    bus.W = '0;
    bus.H_in = '0;
    w_abc = expand({32'h61626380, 448'h0, 32'h00000018});
    w_b1  = expand({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000});
    w_b2  = expand({448'h0, 64'h1c0});

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_h_out", bus.H_out, 256'h0);
    check("reset_en_next", 256'(bus.en_next), 256'h0);
    check("reset_busy", 256'(bus.busy), 256'h0);

    check("model_abc", ref_compress(w_abc, IV), ABC_DIG);
    start(1'b0, w_abc, IV);
    wait_done(-1, lat, bcnt, dc1);
    check("abc_latency", 256'(lat), 256'(LAT));
    check("abc_busy_cycles", 256'(bcnt), 256'(LAT));
    check("abc_digest", bus.H_out, ABC_DIG);
    @(negedge clk);
    check("en_next_single", 256'(bus.en_next), 256'h0);
    check("h_out_hold", bus.H_out, ABC_DIG);

    start(1'b0, w_b1, IV);
    wait_done(-1, lat, bcnt, dc1);
    check("two_blk1", bus.H_out, ref_compress(w_b1, IV));
    dig1 = bus.H_out;
    start(1'b0, w_b2, dig1);
    wait_done(-1, lat, bcnt, dc1);
    check("two_blk2", bus.H_out, TWO_DIG);

    start(1'b0, w_abc, IV);
    wait_done(10, lat, bcnt, dc1);
    check("inject_latency", 256'(lat), 256'(LAT));
    check("inject_digest", bus.H_out, ABC_DIG);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.en_next || bus.busy) pulses++;
    end
    check("inject_not_queued", 256'(pulses), 256'h0);

    w_r = rand_w();
    h_r = rand_h();
    start(1'b0, w_abc, IV);
    wait_done(-1, lat, bcnt, dc1);
    check("b2b_first", bus.H_out, ABC_DIG);
    start(1'b1, w_r, h_r);
    wait_done(-1, lat, bcnt, dc2);
    check("b2b_gap", 256'(dc2 - dc1), 256'(LAT + 1));
    check("b2b_second", bus.H_out, ref_compress(w_r, h_r));

    start(1'b0, w_abc, IV);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 256'(bus.busy), 256'h0);
    check("abort_h_out", bus.H_out, 256'h0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.en_next) pulses++;
    end
    check("abort_no_en_next", 256'(pulses), 256'h0);
    start(1'b0, w_abc, IV);
    wait_done(-1, lat, bcnt, dc1);
    check("abort_rerun_latency", 256'(lat), 256'(LAT));
    check("abort_rerun_digest", bus.H_out, ABC_DIG);

    for (int r = 0; r < 4; r++) begin
      w_r = rand_w();
      h_r = rand_h();
      start(1'b0, w_r, h_r);
      wait_done(-1, lat, bcnt, dc1);
      check("rand_latency", 256'(lat), 256'(LAT));
      check("rand_digest", bus.H_out, ref_compress(w_r, h_r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
